// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES round sequencer.
// Holds the FSM state encoding, key-length encodings, the round-count
// lookup, the one-hot ARK data-mux codes and the default watchdog limit.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARK  = 3'd1,
        ST_SS   = 3'd2,
        ST_MCKS = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    localparam logic [1:0] KEY_128  = 2'b00;
    localparam logic [1:0] KEY_192  = 2'b01;
    localparam logic [1:0] KEY_256  = 2'b10;
    localparam logic [1:0] KEY_RSVD = 2'b11;

    localparam logic [2:0] ARK_SEL_NONE = 3'b000;
    localparam logic [2:0] ARK_SEL_PT   = 3'b001;
    localparam logic [2:0] ARK_SEL_SS   = 3'b010;
    localparam logic [2:0] ARK_SEL_MC   = 3'b100;

    localparam int TIMEOUT_DEF = 64;

    // Number of rounds for a key length; reserved code maps to 0.
    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_128: nr_of = 4'd10;
            KEY_192: nr_of = 4'd12;
            KEY_256: nr_of = 4'd14;
            default: nr_of = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_wdog.sv
// Per-state watchdog for the AES round sequencer.
// Ports: clk, rst (async, active-high); clr restarts the count at 0;
// en counts cycles spent in a wait state; expired flags the last
// permitted cycle (count == TIMEOUT-1) so the FSM leaves after
// exactly TIMEOUT cycles.
module aes_wdog
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expired = en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/aes_round_seq.sv
// AES round sequencer: drives AddRoundKey, ShiftRows/SubBytes,
// MixColumns and key-schedule units through Nr rounds.
// Ports: clk, rst (async, active-high); load_in/key_len_in start an
// operation; *_ready_in are unit-complete pulses; *_start_out are
// one-cycle start pulses; round_out, key_sel, ark_in_sel steer the
// datapath; busy_out, done_out, err_out report status.
//
// state | meaning
// IDLE  | waiting for load_in
// ARK   | AddRoundKey running
// SS    | ShiftRows/SubBytes running
// MCKS  | MixColumns and key schedule running in parallel
// DONE  | one-cycle completion
// ERR   | reserved key length or watchdog expiry
module aes_round_seq
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_in,
    input  logic [1:0]         key_len_in,
    input  logic               ss_ready_in,
    input  logic               mc_ready_in,
    input  logic               ks_ready_in,
    input  logic               ark_ready_in,
    output logic               ss_start_out,
    output logic               mc_start_out,
    output logic               ks_start_out,
    output logic               ark_start_out,
    output logic [ROUND_W-1:0] round_out,
    output logic               key_sel,
    output logic [2:0]         ark_in_sel,
    output logic               busy_out,
    output logic               done_out,
    output logic               err_out
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [ROUND_W-1:0] r_round;
    logic [ROUND_W-1:0] r_nr;
    logic               r_first;
    logic               r_ark_start, r_ss_start, r_mc_start, r_ks_start;
    logic               r_ks_seen, r_mc_seen;
    logic               r_err;
    logic               w_entry, w_last, w_wd_en, w_wd_expired;
    logic               w_ark_ok, w_ss_ok, w_mc_ok, w_ks_ok;
    logic               w_ks_have, w_mc_have;

    // Readies landing in the start cycle belong to no request of ours.
    assign w_ark_ok  = ark_ready_in && !r_first;
    assign w_ss_ok   = ss_ready_in  && !r_first;
    assign w_mc_ok   = mc_ready_in  && !r_first;
    assign w_ks_ok   = ks_ready_in  && !r_first;
    assign w_last    = (r_round == r_nr);
    assign w_ks_have = r_ks_seen || w_ks_ok;
    // The final round has no MixColumns, so only the key schedule gates exit.
    assign w_mc_have = r_mc_seen || w_mc_ok || w_last;
    assign w_entry   = (w_state_nxt != r_state);
    assign w_wd_en   = (r_state == ST_ARK) || (r_state == ST_SS) || (r_state == ST_MCKS);

    aes_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_entry),
        .en      (w_wd_en),
        .expired (w_wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (load_in) w_state_nxt = (key_len_in == KEY_RSVD) ? ST_ERR : ST_ARK;
            ST_ARK: begin
                if (w_ark_ok)          w_state_nxt = w_last ? ST_DONE : ST_SS;
                else if (w_wd_expired) w_state_nxt = ST_ERR;
            end
            ST_SS: begin
                if (w_ss_ok)           w_state_nxt = ST_MCKS;
                else if (w_wd_expired) w_state_nxt = ST_ERR;
            end
            ST_MCKS: begin
                if (w_ks_have && w_mc_have) w_state_nxt = ST_ARK;
                else if (w_wd_expired)      w_state_nxt = ST_ERR;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first     <= 1'b0;
            r_ark_start <= 1'b0;
            r_ss_start  <= 1'b0;
            r_mc_start  <= 1'b0;
            r_ks_start  <= 1'b0;
            r_ks_seen   <= 1'b0;
            r_mc_seen   <= 1'b0;
            r_round     <= '0;
            r_nr        <= '0;
            r_err       <= 1'b0;
        end else begin
            r_first     <= w_entry;
            r_ark_start <= w_entry && (w_state_nxt == ST_ARK);
            r_ss_start  <= w_entry && (w_state_nxt == ST_SS);
            r_ks_start  <= w_entry && (w_state_nxt == ST_MCKS);
            r_mc_start  <= w_entry && (w_state_nxt == ST_MCKS) && (r_round < r_nr);

            if (r_state == ST_MCKS && w_state_nxt == ST_MCKS) begin
                r_ks_seen <= w_ks_have;
                r_mc_seen <= r_mc_seen || w_mc_ok;
            end else begin
                r_ks_seen <= 1'b0;
                r_mc_seen <= 1'b0;
            end

            if (r_state == ST_IDLE && w_state_nxt == ST_ARK) begin
                r_nr    <= ROUND_W'(nr_of(key_len_in));
                r_round <= '0;
                r_err   <= 1'b0;
            end else if (r_state == ST_ARK && w_state_nxt == ST_SS) begin
                r_round <= r_round + ROUND_W'(1);
            end else if (w_state_nxt == ST_IDLE) begin
                r_round <= '0;
            end

            if (w_state_nxt == ST_ERR) r_err <= 1'b1;
        end
    end

    always_comb begin
        busy_out   = 1'b0;
        done_out   = 1'b0;
        ark_in_sel = ARK_SEL_NONE;
        key_sel    = 1'b0;
        case (r_state)
            ST_ARK, ST_SS, ST_MCKS: busy_out = 1'b1;
            ST_DONE: begin
                busy_out = 1'b1;
                done_out = 1'b1;
            end
            default: ;
        endcase
        if (r_state != ST_IDLE && r_state != ST_ERR) begin
            if (r_round == '0) ark_in_sel = ARK_SEL_PT;
            else if (w_last)   ark_in_sel = ARK_SEL_SS;
            else               ark_in_sel = ARK_SEL_MC;
            key_sel = (r_round >= ROUND_W'(2));
        end
    end

    assign ark_start_out = r_ark_start;
    assign ss_start_out  = r_ss_start;
    assign mc_start_out  = r_mc_start;
    assign ks_start_out  = r_ks_start;
    assign round_out     = r_round;
    assign err_out       = r_err;

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq: table of full runs with configurable unit
// response delays, plus hand-written timeout and mid-run reset sequences.
module tb_aes_round_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_in = 1'b0;
    logic [1:0] key_len_in = 2'b00;
    logic       ss_ready_in = 1'b0, mc_ready_in = 1'b0, ks_ready_in = 1'b0, ark_ready_in = 1'b0;
    logic       ss_start_out, mc_start_out, ks_start_out, ark_start_out;
    logic [3:0] round_out;
    logic       key_sel;
    logic [2:0] ark_in_sel;
    logic       busy_out, done_out, err_out;

    aes_round_seq #(.TIMEOUT(64), .ROUND_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_in       (load_in),
        .key_len_in    (key_len_in),
        .ss_ready_in   (ss_ready_in),
        .mc_ready_in   (mc_ready_in),
        .ks_ready_in   (ks_ready_in),
        .ark_ready_in  (ark_ready_in),
        .ss_start_out  (ss_start_out),
        .mc_start_out  (mc_start_out),
        .ks_start_out  (ks_start_out),
        .ark_start_out (ark_start_out),
        .round_out     (round_out),
        .key_sel       (key_sel),
        .ark_in_sel    (ark_in_sel),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .err_out       (err_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Unit models: index 0 ark, 1 ss, 2 mc, 3 ks. A delay d means the
    // ready pulse lands d cycles after the start cycle; 0 means never.
    int   dly[4] = '{1, 1, 1, 1};
    int   cd[4]  = '{0, 0, 0, 0};
    logic rn[4];
    logic st_v[4];

    always begin
        @(negedge clk);
        st_v[0] = ark_start_out;
        st_v[1] = ss_start_out;
        st_v[2] = mc_start_out;
        st_v[3] = ks_start_out;
        for (int i = 0; i < 4; i++) begin
            if (rst)          cd[i] = 0;
            else if (st_v[i]) cd[i] = dly[i];
            rn[i] = (cd[i] == 1);
            if (cd[i] > 0) cd[i]--;
        end
        @(posedge clk);
        #1;
        ark_ready_in = rn[0];
        ss_ready_in  = rn[1];
        mc_ready_in  = rn[2];
        ks_ready_in  = rn[3];
    end

    // Start-pulse counters and a mux/round-progression model.
    int         n_ark = 0, n_ss = 0, n_mc = 0, n_ks = 0;
    int         sel_bad = 0;
    int         last_round = 0;
    int         cur_nr = 10;
    logic [2:0] e_sel;
    logic       e_key;

    always @(negedge clk) begin
        if (ark_start_out) n_ark++;
        if (ss_start_out)  n_ss++;
        if (mc_start_out)  n_mc++;
        if (ks_start_out)  n_ks++;
        if (busy_out) begin
            if (round_out == 4'd0)           e_sel = 3'b001;
            else if (int'(round_out) == cur_nr) e_sel = 3'b010;
            else                             e_sel = 3'b100;
            e_key = (round_out >= 4'd2);
            if (ark_in_sel != e_sel || key_sel != e_key) sel_bad++;
            if (int'(round_out) != last_round) begin
                if (int'(round_out) != last_round + 1) sel_bad++;
                last_round = int'(round_out);
            end
        end else begin
            last_round = 0;
        end
    end

    typedef struct {
        logic [1:0] kl;
        int         d_ark, d_ss, d_mc, d_ks;
        int         nr, lat;
        bit         err;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input int idx);
        vec_t v;
        int   cyc, b_ark, b_ss, b_mc, b_ks, b_bad;
        bit   seen;
        v = vecs[idx];
        dly[0] = v.d_ark; dly[1] = v.d_ss; dly[2] = v.d_mc; dly[3] = v.d_ks;
        cur_nr = v.nr;
        @(negedge clk);
        b_ark = n_ark; b_ss = n_ss; b_mc = n_mc; b_ks = n_ks; b_bad = sel_bad;
        load_in = 1'b1;
        key_len_in = v.kl;
        cyc = 0;
        seen = 1'b0;
        if (v.err) begin
            @(posedge clk); #1;
            load_in = 1'b0;
            chk($sformatf("v%0d_err_set", idx), err_out, 1);
            chk($sformatf("v%0d_err_busy", idx), busy_out, 0);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("v%0d_err_sticky", idx), err_out, 1);
            chk($sformatf("v%0d_err_done", idx), done_out, 0);
            chk($sformatf("v%0d_err_starts", idx),
                (n_ark - b_ark) + (n_ss - b_ss) + (n_mc - b_mc) + (n_ks - b_ks), 0);
        end else begin
            while (!seen && cyc < 400) begin
                @(posedge clk); #1;
                cyc++;
                load_in = 1'b0;
                if (cyc == 1) chk($sformatf("v%0d_err_clear", idx), err_out, 0);
                seen = done_out;
            end
            chk($sformatf("v%0d_latency", idx), seen ? cyc : -1, v.lat);
            chk($sformatf("v%0d_round_at_done", idx), round_out, v.nr);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_one_cycle", idx), done_out, 0);
            chk($sformatf("v%0d_busy_after", idx), busy_out, 0);
            chk($sformatf("v%0d_round_after", idx), round_out, 0);
            chk($sformatf("v%0d_ark_pulses", idx), n_ark - b_ark, v.nr + 1);
            chk($sformatf("v%0d_ss_pulses", idx), n_ss - b_ss, v.nr);
            chk($sformatf("v%0d_mc_pulses", idx), n_mc - b_mc, v.nr - 1);
            chk($sformatf("v%0d_ks_pulses", idx), n_ks - b_ks, v.nr);
            chk($sformatf("v%0d_sel_round_errors", idx), sel_bad - b_bad, 0);
        end
    endtask

    initial begin
        int cyc;
        bit seen;
        //          kl     ark ss mc ks nr  lat  err
        vecs[0] = '{2'b00, 1, 1, 1, 1, 10, 63,  1'b0};
        vecs[1] = '{2'b01, 1, 1, 1, 1, 12, 75,  1'b0};
        vecs[2] = '{2'b10, 1, 1, 1, 1, 14, 87,  1'b0};
        vecs[3] = '{2'b00, 1, 1, 4, 1, 10, 90,  1'b0};  // ks 3 cycles before mc
        vecs[4] = '{2'b00, 1, 1, 1, 3, 10, 83,  1'b0};  // mc before ks
        vecs[5] = '{2'b01, 1, 1, 2, 2, 12, 87,  1'b0};  // mc and ks together
        vecs[6] = '{2'b10, 2, 1, 1, 1, 14, 102, 1'b0};
        vecs[7] = '{2'b11, 1, 1, 1, 1, 0,  0,   1'b1};
        vecs[8] = '{2'b00, 1, 1, 1, 1, 10, 63,  1'b0};  // clears sticky error

        #3;
        chk("reset_round", round_out, 0);
        chk("reset_ark_sel", ark_in_sel, 0);
        chk("reset_key_sel", key_sel, 0);
        chk("reset_busy", busy_out, 0);
        chk("reset_done", done_out, 0);
        chk("reset_err", err_out, 0);
        chk("reset_starts", {ark_start_out, ss_start_out, mc_start_out, ks_start_out}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i);

        // Watchdog: ShiftSub never answers; stray loads while busy.
        dly[0] = 1; dly[1] = 0; dly[2] = 1; dly[3] = 1;
        cur_nr = 10;
        @(negedge clk);
        load_in = 1'b1;
        key_len_in = 2'b00;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            load_in = (cyc == 10) || (cyc == 40);
            key_len_in = 2'b10;
            seen = err_out;
        end
        load_in = 1'b0;
        chk("timeout_err_cycle", seen ? cyc : -1, 67);
        chk("timeout_busy", busy_out, 0);
        chk("timeout_round", round_out, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("timeout_err_sticky", err_out, 1);
        chk("timeout_idle_busy", busy_out, 0);
        run_vec(0);

        // Reset in the middle of round 5.
        dly[0] = 1; dly[1] = 1; dly[2] = 1; dly[3] = 1;
        cur_nr = 10;
        @(negedge clk);
        load_in = 1'b1;
        key_len_in = 2'b00;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            load_in = 1'b0;
            seen = (round_out == 4'd5);
        end
        chk("midrst_round5_cycle", seen ? cyc : -1, 27);
        chk("midrst_ss_start_before", ss_start_out, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_round", round_out, 0);
        chk("midrst_busy", busy_out, 0);
        chk("midrst_ark_sel", ark_in_sel, 0);
        chk("midrst_key_sel", key_sel, 0);
        chk("midrst_starts", {ark_start_out, ss_start_out, mc_start_out, ks_start_out}, 0);
        chk("midrst_done_err", {done_out, err_out}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_vec(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired, expected finish");
        $fatal(1);
    end

endmodule
